// File: rtl/mem_requester_if.sv
// Bundles used by mem_requester.
// mem_cmd_if: core-side command/response channel. The master (core) drives
//   cmd_* and the slave (requester) returns cmd_ready and resp_*.
// mem_bus_if: memory-side request/ack bus. The master (requester) drives
//   mem_rd_req/mem_wr_req/mem_addr/mem_wr_data, and the slave (memory)
//   returns mem_rd_data/mem_busy/mem_ack.

interface mem_cmd_if #(
  parameter int addr_width = 32,
  parameter int data_width = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [1:0]            cmd_size;
  logic                  cmd_signed;
  logic [addr_width-1:0] cmd_addr;
  logic [data_width-1:0] cmd_wr_data;
  logic                  resp_valid;
  logic [data_width-1:0] resp_rd_data;
  logic                  resp_err;

  modport master (
    output cmd_valid, cmd_wr, cmd_size, cmd_signed, cmd_addr, cmd_wr_data,
    input  cmd_ready, resp_valid, resp_rd_data, resp_err
  );
  modport slave (
    input  cmd_valid, cmd_wr, cmd_size, cmd_signed, cmd_addr, cmd_wr_data,
    output cmd_ready, resp_valid, resp_rd_data, resp_err
  );
endinterface

interface mem_bus_if #(
  parameter int addr_width = 32,
  parameter int data_width = 32
);
  logic                  mem_rd_req;
  logic                  mem_wr_req;
  logic [addr_width-1:0] mem_addr;
  logic [data_width-1:0] mem_wr_data;
  logic [data_width-1:0] mem_rd_data;
  logic                  mem_busy;
  logic                  mem_ack;

  modport master (
    output mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
    input  mem_rd_data, mem_busy, mem_ack
  );
  modport slave (
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
    output mem_rd_data, mem_busy, mem_ack
  );
endinterface

// File: rtl/mem_requester.sv
// mem_requester: turns one core load/store command at a time into word-aligned
// memory requests. Sub-word stores are done as read-modify-write; sub-word
// loads are lane-extracted and sign/zero-extended. One response per command.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1; cmd_ready depends only on state and mem_busy, never
// on cmd_valid. resp_valid, mem_rd_req and mem_wr_req are single-cycle pulses
// with no back-pressure; mem_ack is honoured only while in a wait state.
// Byte/half lane logic assumes data_width == 32.

module mem_requester #(
  parameter int addr_width     = 32,
  parameter int data_width     = 32,
  parameter int timeout_cycles = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_cmd_if.slave   cmd_if,
  mem_bus_if.master  mem_if,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WAIT, WR_WAIT} state_e;

  localparam int            CW      = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles + 1);
  localparam logic [CW:0]   TO_LIM  = timeout_cycles[CW:0];
  localparam logic [CW:0]   CNT_ONE = {{CW{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            lane_q, lane_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [addr_width-1:0] mem_addr_q, mem_addr_d;
  logic [data_width-1:0] mem_wr_data_q, mem_wr_data_d;
  logic                  rd_req_q, rd_req_d;
  logic                  wr_req_q, wr_req_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [data_width-1:0] resp_data_q, resp_data_d;

  logic                  cmd_accept;
  logic                  misaligned;
  logic [CW:0]           cnt_inc;
  logic                  timed_out;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [data_width-1:0] load_data;
  logic [data_width-1:0] merged;

  assign cmd_if.cmd_ready = (state_q == IDLE) && !mem_if.mem_busy && rst_n;
  assign cmd_accept       = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign cnt_inc          = {1'b0, cnt_q} + CNT_ONE;
  assign timed_out        = (timeout_cycles != 0) && (cnt_inc == TO_LIM);

  // Alignment/size legality of the command currently offered
  always_comb begin
    misaligned = 1'b0;
    case (cmd_if.cmd_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = cmd_if.cmd_addr[0];
      2'b10:   misaligned = (cmd_if.cmd_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Lane extraction for loads and lane merge for read-modify-write stores
  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = 16'h0000;
    load_data = mem_if.mem_rd_data;
    merged    = mem_if.mem_rd_data;
    case (lane_q)
      2'd0:    byte_sel = mem_if.mem_rd_data[7:0];
      2'd1:    byte_sel = mem_if.mem_rd_data[15:8];
      2'd2:    byte_sel = mem_if.mem_rd_data[23:16];
      default: byte_sel = mem_if.mem_rd_data[31:24];
    endcase
    half_sel = lane_q[1] ? mem_if.mem_rd_data[31:16] : mem_if.mem_rd_data[15:0];
    if (size_q == 2'b00) begin
      load_data = {{(data_width-8){signed_q & byte_sel[7]}}, byte_sel};
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (size_q == 2'b01) begin
      load_data = {{(data_width-16){signed_q & half_sel[15]}}, half_sel};
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lane_d        = lane_q;
    size_d        = size_q;
    signed_d      = signed_q;
    wdata_d       = wdata_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rd_req_d      = 1'b0;
    wr_req_d      = 1'b0;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_data_d   = '0;
    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          if (misaligned) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            lane_d     = cmd_if.cmd_addr[1:0];
            size_d     = cmd_if.cmd_size;
            signed_d   = cmd_if.cmd_signed;
            wdata_d    = cmd_if.cmd_wr_data[15:0];
            mem_addr_d = {cmd_if.cmd_addr[addr_width-1:2], 2'b00};
            cnt_d      = '0;
            if (!cmd_if.cmd_wr) begin
              rd_req_d = 1'b1;
              state_d  = RD_WAIT;
            end else if (cmd_if.cmd_size == 2'b10) begin
              wr_req_d      = 1'b1;
              mem_wr_data_d = cmd_if.cmd_wr_data;
              state_d       = WR_WAIT;
            end else begin
              rd_req_d = 1'b1;
              state_d  = RMW_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (mem_if.mem_ack) begin
          resp_valid_d = 1'b1;
          resp_data_d  = load_data;
          state_d      = IDLE;
        end else if (timed_out) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end
      RMW_WAIT: begin
        if (mem_if.mem_ack) begin
          // The write phase gets its own fresh timeout window
          wr_req_d      = 1'b1;
          mem_wr_data_d = merged;
          cnt_d         = '0;
          state_d       = WR_WAIT;
        end else if (timed_out) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end
      default: begin
        if (mem_if.mem_ack) begin
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end else if (timed_out) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end
    endcase
  end

  // State and output registers; reset aborts any transaction silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      lane_q        <= 2'b00;
      size_q        <= 2'b00;
      signed_q      <= 1'b0;
      wdata_q       <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rd_req_q      <= 1'b0;
      wr_req_q      <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lane_q        <= lane_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      wdata_q       <= wdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rd_req_q      <= rd_req_d;
      wr_req_q      <= wr_req_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_data_q   <= resp_data_d;
    end
  end

  assign mem_if.mem_rd_req   = rd_req_q;
  assign mem_if.mem_wr_req   = wr_req_q;
  assign mem_if.mem_addr     = mem_addr_q;
  assign mem_if.mem_wr_data  = mem_wr_data_q;
  assign cmd_if.resp_valid   = resp_valid_q;
  assign cmd_if.resp_err     = resp_err_q;
  assign cmd_if.resp_rd_data = resp_data_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester. dut_a (default timeout) is served by a
// delayed-ack memory model; dut_b (timeout_cycles=4) has its memory side
// driven by hand to exercise timeout and late-ack handling.

module tb_mem_requester;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_cmd_if cmd_a ();
  mem_bus_if bus_a ();
  mem_cmd_if cmd_b ();
  mem_bus_if bus_b ();
  logic [1:0] state_a;
  logic [1:0] state_b;

  mem_requester dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd_if  (cmd_a),
    .mem_if  (bus_a),
    .state_o (state_a)
  );

  mem_requester #(.timeout_cycles(4)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd_if  (cmd_b),
    .mem_if  (bus_b),
    .state_o (state_b)
  );

  int checks = 0;
  int errors = 0;

  // Memory model controls (written by the main sequence only)
  int          ack_delay = 0;
  logic [31:0] mem_word  = 32'h0;
  // Memory model observations (written by the responder only)
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_rd_addr = 32'h0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  // ---------------- delayed-ack memory for dut_a ----------------
  initial begin : responder
    int   rem;
    bit   pend;
    bit   is_rd;
    logic [31:0] wdat;
    rem = 0; pend = 0; is_rd = 0; wdat = 32'h0;
    bus_a.mem_busy = 1'b0; bus_a.mem_ack = 1'b0; bus_a.mem_rd_data = 32'h0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        pend = 0;
        bus_a.mem_busy = 1'b0; bus_a.mem_ack = 1'b0; bus_a.mem_rd_data = 32'h0;
      end else begin
        bus_a.mem_ack = 1'b0;
        bus_a.mem_rd_data = 32'h0;
        if (bus_a.mem_rd_req || bus_a.mem_wr_req) begin
          pend  = 1;
          rem   = ack_delay;
          is_rd = bus_a.mem_rd_req;
          wdat  = bus_a.mem_wr_data;
          if (is_rd) begin
            rd_cnt++;
            last_rd_addr = bus_a.mem_addr;
          end else begin
            wr_cnt++;
            last_wr_addr = bus_a.mem_addr;
            last_wr_data = wdat;
          end
        end else if (pend && rem > 0) begin
          rem--;
        end
        if (pend && rem == 0) begin
          bus_a.mem_ack = 1'b1;
          if (is_rd) bus_a.mem_rd_data = mem_word;
          pend = 0;
        end
        bus_a.mem_busy = pend || bus_a.mem_ack;
      end
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one command on dut_a ----------------
  // lat counts cycles from the command cycle to the response cycle.
  task automatic run_cmd(input string tag, input bit wr, input logic [1:0] size,
                         input bit sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input int delay, input logic [31:0] exp_data, input bit exp_err,
                         input int exp_lat);
    int lat;
    bit got;
    lat = 0;
    got = 0;
    ack_delay = delay;
    for (int i = 0; i < 50 && !cmd_a.cmd_ready; i++) @(negedge clk);
    check({tag, "_ready"}, {31'b0, cmd_a.cmd_ready}, 32'd1);
    cmd_a.cmd_wr = wr; cmd_a.cmd_size = size; cmd_a.cmd_signed = sgn;
    cmd_a.cmd_addr = addr; cmd_a.cmd_wr_data = wdata; cmd_a.cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      lat++;
      cmd_a.cmd_valid = 1'b0;
      if (cmd_a.resp_valid) got = 1;
    end
    check({tag, "_resp_seen"}, {31'b0, got}, 32'd1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, cmd_a.resp_rd_data, exp_data);
    check({tag, "_err"}, {31'b0, cmd_a.resp_err}, {31'b0, exp_err});
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'b0, cmd_a.resp_valid}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int rd0;
    int wr0;
    cmd_a.cmd_valid = 1'b0; cmd_a.cmd_wr = 1'b0; cmd_a.cmd_size = 2'b00;
    cmd_a.cmd_signed = 1'b0; cmd_a.cmd_addr = 32'h0; cmd_a.cmd_wr_data = 32'h0;
    cmd_b.cmd_valid = 1'b0; cmd_b.cmd_wr = 1'b0; cmd_b.cmd_size = 2'b00;
    cmd_b.cmd_signed = 1'b0; cmd_b.cmd_addr = 32'h0; cmd_b.cmd_wr_data = 32'h0;
    bus_b.mem_busy = 1'b0; bus_b.mem_ack = 1'b0; bus_b.mem_rd_data = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_a.cmd_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, cmd_a.resp_valid}, 32'd0);
    check("rst_mem_addr", bus_a.mem_addr, 32'h0);
    check("rst_state", {30'b0, state_a}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", {31'b0, cmd_a.cmd_ready}, 32'd1);

    // Word load, ack after 5 cycles
    mem_word = 32'h8765_4321;
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_cmd("wload", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, 32'h8765_4321, 1'b0, 7);
    check("wload_rd_cnt", rd_cnt - rd0, 1);
    check("wload_wr_cnt", wr_cnt - wr0, 0);
    check("wload_addr", last_rd_addr, 32'h10);

    // Byte loads from 0x80FF_7F01
    mem_word = 32'h80FF_7F01;
    run_cmd("bload_s3", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1, 32'hFFFF_FF80, 1'b0, 3);
    run_cmd("bload_u3", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1, 32'h0000_0080, 1'b0, 3);
    run_cmd("bload_s1", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1, 32'h0000_007F, 1'b0, 3);
    check("bload_addr", last_rd_addr, 32'h10);

    // Half loads from 0x8001_7FFF
    mem_word = 32'h8001_7FFF;
    run_cmd("hload_s2", 1'b0, 2'b01, 1'b1, 32'h02, 32'h0, 3, 32'hFFFF_8001, 1'b0, 5);
    run_cmd("hload_u0", 1'b0, 2'b01, 1'b0, 32'h00, 32'h0, 3, 32'h0000_7FFF, 1'b0, 5);

    // Half store read-modify-write
    mem_word = 32'h1122_3344;
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_cmd("hstore", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 2, 32'h0, 1'b0, 7);
    check("hstore_rd_cnt", rd_cnt - rd0, 1);
    check("hstore_wr_cnt", wr_cnt - wr0, 1);
    check("hstore_rd_addr", last_rd_addr, 32'h20);
    check("hstore_wr_addr", last_wr_addr, 32'h20);
    check("hstore_wr_data", last_wr_data, 32'hBEEF_3344);

    // Byte store read-modify-write, only bits [7:0] of store data used
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_cmd("bstore", 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFA5, 0, 32'h0, 1'b0, 3);
    check("bstore_wr_cnt", wr_cnt - wr0, 1);
    check("bstore_wr_data", last_wr_data, 32'h1122_A544);

    // Word store goes straight to write
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_cmd("wstore", 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D, 0, 32'h0, 1'b0, 2);
    check("wstore_rd_cnt", rd_cnt - rd0, 0);
    check("wstore_wr_cnt", wr_cnt - wr0, 1);
    check("wstore_wr_addr", last_wr_addr, 32'h30);
    check("wstore_wr_data", last_wr_data, 32'hCAFE_F00D);

    // Misaligned / illegal commands: error next cycle, no memory traffic
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_cmd("mis_word", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 0, 32'h0, 1'b1, 1);
    run_cmd("mis_size", 1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 0, 32'h0, 1'b1, 1);
    run_cmd("mis_half", 1'b1, 2'b01, 1'b0, 32'h21, 32'h1234, 0, 32'h0, 1'b1, 1);
    check("mis_rd_cnt", rd_cnt - rd0, 0);
    check("mis_wr_cnt", wr_cnt - wr0, 0);

    // Reset during RMW_WAIT aborts silently
    mem_word = 32'h1122_3344;
    ack_delay = 10;
    cmd_a.cmd_wr = 1'b1; cmd_a.cmd_size = 2'b00; cmd_a.cmd_signed = 1'b0;
    cmd_a.cmd_addr = 32'h05; cmd_a.cmd_wr_data = 32'h77; cmd_a.cmd_valid = 1'b1;
    @(negedge clk);
    cmd_a.cmd_valid = 1'b0;
    check("rmw_rd_req", {31'b0, bus_a.mem_rd_req}, 32'd1);
    check("rmw_addr", bus_a.mem_addr, 32'h04);
    repeat (2) @(negedge clk);
    check("rmw_state", {30'b0, state_a}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_addr", bus_a.mem_addr, 32'h0);
    check("abort_mem_wr_data", bus_a.mem_wr_data, 32'h0);
    check("abort_rd_req", {31'b0, bus_a.mem_rd_req}, 32'd0);
    check("abort_wr_req", {31'b0, bus_a.mem_wr_req}, 32'd0);
    check("abort_cmd_ready", {31'b0, cmd_a.cmd_ready}, 32'd0);
    check("abort_state", {30'b0, state_a}, 32'd0);
    repeat (2) @(negedge clk);
    check("abort_resp_valid", {31'b0, cmd_a.resp_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    mem_word = 32'h0BAD_F00D;
    rd0 = rd_cnt;
    run_cmd("post_rst", 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 4);
    check("post_rst_rd_cnt", rd_cnt - rd0, 1);
    check("post_rst_addr", last_rd_addr, 32'h44);

    // Timeout on dut_b (timeout_cycles=4), memory never acks
    @(negedge clk);
    check("to_ready", {31'b0, cmd_b.cmd_ready}, 32'd1);
    cmd_b.cmd_wr = 1'b0; cmd_b.cmd_size = 2'b10; cmd_b.cmd_addr = 32'h40;
    cmd_b.cmd_valid = 1'b1;
    @(negedge clk);
    cmd_b.cmd_valid = 1'b0;
    check("to_rd_req", {31'b0, bus_b.mem_rd_req}, 32'd1);
    check("to_addr", bus_b.mem_addr, 32'h40);
    bus_b.mem_busy = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("to_wait%0d_resp", i), {31'b0, cmd_b.resp_valid}, 32'd0);
      check($sformatf("to_wait%0d_req", i), {31'b0, bus_b.mem_rd_req}, 32'd0);
    end
    @(negedge clk);
    check("to_resp_valid", {31'b0, cmd_b.resp_valid}, 32'd1);
    check("to_resp_err", {31'b0, cmd_b.resp_err}, 32'd1);
    check("to_resp_data", cmd_b.resp_rd_data, 32'h0);
    check("to_busy_ready", {31'b0, cmd_b.cmd_ready}, 32'd0);
    check("to_state", {30'b0, state_b}, 32'd0);
    bus_b.mem_ack = 1'b1;
    bus_b.mem_rd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("late_resp_valid", {31'b0, cmd_b.resp_valid}, 32'd0);
    check("late_resp_err", {31'b0, cmd_b.resp_err}, 32'd0);
    bus_b.mem_ack = 1'b0;
    bus_b.mem_busy = 1'b0;
    bus_b.mem_rd_data = 32'h0;
    @(negedge clk);
    check("late_resp_valid2", {31'b0, cmd_b.resp_valid}, 32'd0);
    check("late_rd_req", {31'b0, bus_b.mem_rd_req}, 32'd0);
    check("late_state", {30'b0, state_b}, 32'd0);
    check("late_ready", {31'b0, cmd_b.cmd_ready}, 32'd1);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
